multicycle_control: RTL and testbench

- Multi-cycle main control FSM for the RV32I core. It is the producer side of the ALUOp interface: it drives ALUOp (00 add, 01 sub/beq, 10 R-type funct decode) and all datapath enables.
- Sequences fetch, decode, execute, memory and writeback for R-type, lw, sw and beq.
- Handshakes with a variable-latency unified memory via mem_ready.
- Counts retired instructions.

---
 rtl/multicycle_control_pkg.sv | 36 +++
 rtl/multicycle_control_control_out_decode.sv | 88 ++++++++
 rtl/multicycle_control.sv | 89 ++++++++
 tb/tb_multicycle_control.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the RV32I multi-cycle main control: opcodes, ALUOp
// codes, ALU operand selects and the controller state encoding.
package multicycle_control_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  typedef enum logic [3:0] {
    RESET   = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEM_ADR = 4'd3,
    MEM_RD  = 4'd4,
    MEM_WB  = 4'd5,
    MEM_WR  = 4'd6,
    EXEC    = 4'd7,
    ALU_WB  = 4'd8,
    BRANCH  = 4'd9,
    ILLEGAL = 4'd10
  } state_t;

endpackage

// File: rtl/multicycle_control_control_out_decode.sv
// Combinational map from controller state (plus mem_ready and zero for the
// Mealy enables) to every datapath control output.
module control_out_decode
  import multicycle_control_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_mem_ready,
  input  logic       i_zero,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic       o_pc_write,
  output logic       o_pc_source,
  output logic       o_ir_write,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic       o_mem_to_reg,
  output logic       o_retire,
  output logic       o_illegal
);

  always_comb begin
    o_alu_op     = ALUOP_ADD;
    o_alu_src_a  = SRCA_PC;
    o_alu_src_b  = SRCB_RS2;
    o_pc_write   = 1'b0;
    o_pc_source  = 1'b0;
    o_ir_write   = 1'b0;
    o_iord       = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_reg_write  = 1'b0;
    o_mem_to_reg = 1'b0;
    o_retire     = 1'b0;
    o_illegal    = 1'b0;
    case (i_state)
      FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = SRCB_FOUR;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      DECODE: begin
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_IMM;
      end
      MEM_ADR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      MEM_WB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = 1'b1;
        o_retire     = 1'b1;
      end
      MEM_WR: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
        o_retire    = i_mem_ready;
      end
      EXEC: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_op    = ALUOP_RTYPE;
      end
      ALU_WB: begin
        o_reg_write = 1'b1;
        o_retire    = 1'b1;
      end
      // Branch target was parked in ALUOut during DECODE; PC loads it on zero.
      BRANCH: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_op    = ALUOP_BRANCH;
        o_pc_source = 1'b1;
        o_pc_write  = i_zero;
        o_retire    = 1'b1;
      end
      ILLEGAL: o_illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main control FSM for the RV32I core: sequences R-type, lw, sw and
// beq against a variable-latency memory and counts retired instructions.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic [1:0]           ALUOp,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 pc_write,
  output logic                 pc_source,
  output logic                 ir_write,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 illegal
);

  state_t                 r_state;
  state_t                 w_next_state;
  logic   [INSTRET_W-1:0] r_instret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RESET;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RESET:   w_next_state = FETCH;
      FETCH:   if (mem_ready) w_next_state = DECODE;
      DECODE: begin
        case (opcode)
          OPC_RTYPE:           w_next_state = EXEC;
          OPC_LOAD, OPC_STORE: w_next_state = MEM_ADR;
          OPC_BRANCH:          w_next_state = BRANCH;
          default:             w_next_state = ILLEGAL;
        endcase
      end
      MEM_ADR: w_next_state = (opcode == OPC_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:  if (mem_ready) w_next_state = MEM_WB;
      MEM_WB:  w_next_state = FETCH;
      MEM_WR:  if (mem_ready) w_next_state = FETCH;
      EXEC:    w_next_state = ALU_WB;
      ALU_WB:  w_next_state = FETCH;
      BRANCH:  w_next_state = FETCH;
      ILLEGAL: w_next_state = ILLEGAL;
      default: w_next_state = RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_instret <= '0;
    else if (retire) r_instret <= r_instret + INSTRET_W'(1);
  end

  assign instret = r_instret;

  control_out_decode u_control_out_decode (
    .i_state      (r_state),
    .i_mem_ready  (mem_ready),
    .i_zero       (zero),
    .o_alu_op     (ALUOp),
    .o_alu_src_a  (alu_src_a),
    .o_alu_src_b  (alu_src_b),
    .o_pc_write   (pc_write),
    .o_pc_source  (pc_source),
    .o_ir_write   (ir_write),
    .o_iord       (iord),
    .o_mem_read   (mem_read),
    .o_mem_write  (mem_write),
    .o_reg_write  (reg_write),
    .o_mem_to_reg (mem_to_reg),
    .o_retire     (retire),
    .o_illegal    (illegal)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors for each
// instruction class, plus reset-abort, illegal-opcode and counter-wrap cases.
module tb_multicycle_control;

  localparam logic [6:0] ADD = 7'b0110011;
  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] BAD = 7'b0010011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [1:0]  ALUOp, alu_src_a, alu_src_b;
  logic        pc_write, pc_source, ir_write, iord, mem_read, mem_write;
  logic        reg_write, mem_to_reg, retire, illegal;
  logic [31:0] instret;

  logic [1:0]  sALUOp, sSrcA, sSrcB;
  logic        sPcWrite, sPcSource, sIrWrite, sIord, sMemRead, sMemWrite;
  logic        sRegWrite, sMemToReg, sRetire, sIllegal;
  logic [2:0]  sInstret;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_write(pc_write), .pc_source(pc_source), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .retire(retire), .instret(instret), .illegal(illegal)
  );

  // Narrow counter copy sees identical stimulus so wrap-around is reachable.
  multicycle_control #(.INSTRET_W(3)) dutSmall (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALUOp(sALUOp), .alu_src_a(sSrcA), .alu_src_b(sSrcB),
    .pc_write(sPcWrite), .pc_source(sPcSource), .ir_write(sIrWrite), .iord(sIord),
    .mem_read(sMemRead), .mem_write(sMemWrite), .reg_write(sRegWrite),
    .mem_to_reg(sMemToReg), .retire(sRetire), .instret(sInstret), .illegal(sIllegal)
  );

  typedef struct {
    logic [6:0]  opc;
    logic        rdy;
    logic        z;
    logic [15:0] exp;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  logic [15:0] eReset, eFetch0, eFetch1, eDecode, eMemAdr, eMemRd, eMemWb;
  logic [15:0] eMemWr0, eMemWr1, eExec, eAluWb, eBr0, eBr1, eIll;

  function automatic logic [15:0] cv(int aop, int sa, int sb, int pcw, int pcs, int irw,
                                     int io, int mr, int mw, int rw, int m2r, int ret, int ill);
    logic [1:0] a2, sa2, sb2;
    a2 = aop[1:0]; sa2 = sa[1:0]; sb2 = sb[1:0];
    return {a2, sa2, sb2, pcw[0], pcs[0], irw[0], io[0], mr[0], mw[0], rw[0], m2r[0],
            ret[0], ill[0]};
  endfunction

  function automatic logic [15:0] dutVec();
    return {ALUOp, alu_src_a, alu_src_b, pc_write, pc_source, ir_write, iord,
            mem_read, mem_write, reg_write, mem_to_reg, retire, illegal};
  endfunction

  function automatic logic [15:0] smallVec();
    return {sALUOp, sSrcA, sSrcB, sPcWrite, sPcSource, sIrWrite, sIord,
            sMemRead, sMemWrite, sRegWrite, sMemToReg, sRetire, sIllegal};
  endfunction

  task automatic addVec(input logic [6:0] o, input logic r, input logic z,
                        input logic [15:0] e, input int c);
    vec_t v;
    v.opc = o; v.rdy = r; v.z = z; v.exp = e; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, check after settling, then move to next negedge.
  task automatic applyStimulus(input string name, input logic [6:0] o, input logic r,
                               input logic z, input logic [15:0] e, input int c);
    logic [31:0] c32;
    c32 = c;
    opcode = o; mem_ready = r; zero = z;
    #2;
    checkOutput({name, " ctrl"}, {16'd0, dutVec()}, {16'd0, e});
    checkOutput({name, " instret"}, instret, c32);
    checkOutput({name, " ctrl_w3"}, {16'd0, smallVec()}, {16'd0, e});
    checkOutput({name, " instret_w3"}, {29'd0, sInstret}, {29'd0, c32[2:0]});
    @(negedge clk);
  endtask

  initial begin
    eReset  = cv(0,0,0, 0,0,0,0,0,0,0,0,0,0);
    eFetch0 = cv(0,0,1, 0,0,0,0,1,0,0,0,0,0);
    eFetch1 = cv(0,0,1, 1,0,1,0,1,0,0,0,0,0);
    eDecode = cv(0,1,2, 0,0,0,0,0,0,0,0,0,0);
    eMemAdr = cv(0,2,2, 0,0,0,0,0,0,0,0,0,0);
    eMemRd  = cv(0,0,0, 0,0,0,1,1,0,0,0,0,0);
    eMemWb  = cv(0,0,0, 0,0,0,0,0,0,1,1,1,0);
    eMemWr0 = cv(0,0,0, 0,0,0,1,0,1,0,0,0,0);
    eMemWr1 = cv(0,0,0, 0,0,0,1,0,1,0,0,1,0);
    eExec   = cv(2,2,0, 0,0,0,0,0,0,0,0,0,0);
    eAluWb  = cv(0,0,0, 0,0,0,0,0,0,1,0,1,0);
    eBr0    = cv(1,2,0, 0,1,0,0,0,0,0,0,1,0);
    eBr1    = cv(1,2,0, 1,1,0,0,0,0,0,0,1,0);
    eIll    = cv(0,0,0, 0,0,0,0,0,0,0,0,0,1);

    addVec(ADD, 1, 0, eReset, 0);
    // add: 4 cycles
    addVec(ADD, 1, 0, eFetch1, 0); addVec(ADD, 0, 1, eDecode, 0);
    addVec(ADD, 0, 1, eExec, 0);   addVec(ADD, 1, 0, eAluWb, 0);
    // lw with two wait cycles in MEM_RD: 7 cycles
    addVec(LW, 1, 0, eFetch1, 1);  addVec(LW, 0, 0, eDecode, 1);
    addVec(LW, 0, 0, eMemAdr, 1);  addVec(LW, 0, 0, eMemRd, 1);
    addVec(LW, 0, 0, eMemRd, 1);   addVec(LW, 1, 0, eMemRd, 1);
    addVec(LW, 0, 0, eMemWb, 1);
    // sw, memory ready: 4 cycles
    addVec(SW, 1, 0, eFetch1, 2);  addVec(SW, 1, 0, eDecode, 2);
    addVec(SW, 1, 0, eMemAdr, 2);  addVec(SW, 1, 0, eMemWr1, 2);
    // sw with a wait in FETCH and in MEM_WR
    addVec(SW, 0, 0, eFetch0, 3);  addVec(SW, 1, 0, eFetch1, 3);
    addVec(SW, 0, 0, eDecode, 3);  addVec(SW, 0, 0, eMemAdr, 3);
    addVec(SW, 0, 0, eMemWr0, 3);  addVec(SW, 1, 0, eMemWr1, 3);
    // beq taken then not taken
    addVec(BEQ, 1, 1, eFetch1, 4); addVec(BEQ, 0, 1, eDecode, 4);
    addVec(BEQ, 0, 1, eBr1, 4);
    addVec(BEQ, 1, 0, eFetch1, 5); addVec(BEQ, 1, 0, eDecode, 5);
    addVec(BEQ, 1, 0, eBr0, 5);
    // two more beq push the 3-bit copy through 7 -> 0
    addVec(BEQ, 1, 0, eFetch1, 6); addVec(BEQ, 1, 0, eDecode, 6);
    addVec(BEQ, 1, 1, eBr1, 6);
    addVec(BEQ, 1, 0, eFetch1, 7); addVec(BEQ, 1, 0, eDecode, 7);
    addVec(BEQ, 0, 0, eBr0, 7);
    addVec(ADD, 1, 0, eFetch1, 8);

    opcode = ADD; mem_ready = 1'b1; zero = 1'b0;
    #2;
    checkOutput("reset ctrl", {16'd0, dutVec()}, 32'd0);
    checkOutput("reset instret", instret, 32'd0);
    @(negedge clk);
    checkOutput("reset held ctrl", {16'd0, dutVec()}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus($sformatf("vec%0d", i), vecs[i].opc, vecs[i].rdy, vecs[i].z,
                    vecs[i].exp, vecs[i].cnt);

    // Now in DECODE; take a sw into MEM_WR, stall, then reset mid-write.
    applyStimulus("abort decode", SW, 0, 0, eDecode, 8);
    applyStimulus("abort adr", SW, 0, 0, eMemAdr, 8);
    opcode = SW; mem_ready = 1'b0;
    #2;
    checkOutput("abort mem_write before", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort mem_write async", {31'd0, mem_write}, 32'd0);
    checkOutput("abort ctrl", {16'd0, dutVec()}, 32'd0);
    checkOutput("abort instret", instret, 32'd0);
    checkOutput("abort instret_w3", {29'd0, sInstret}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("ill reset", BAD, 1, 0, eReset, 0);
    applyStimulus("ill fetch", BAD, 1, 0, eFetch1, 0);
    applyStimulus("ill decode", BAD, 1, 0, eDecode, 0);
    for (int k = 0; k < 20; k++)
      applyStimulus($sformatf("ill sticky%0d", k), 7'($urandom_range(0, 127)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), eIll, 0);

    rst_n = 1'b0;
    #1;
    checkOutput("ill cleared", {31'd0, illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("resume reset", ADD, 1, 0, eReset, 0);
    applyStimulus("resume fetch", ADD, 1, 0, eFetch1, 0);
    applyStimulus("resume decode", ADD, 1, 0, eDecode, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
